spi_xfer_scheduler: RTL

Shares one SPI master datapath between NUM_REQ requesters, and sequences every transfer on it. Each requester posts a transfer descriptor: a mode (00 none, 01 MOSI-only, 10 MISO-only, 11 full duplex) plus a transmit word. A round-robin arbiter picks one descriptor and drives the master's req/din. The block waits for the mode-appropriate done strobes, returns the received word to the winning requester, then enforces an idle gap before the next grant. A per-transfer timeout protects against a hung slave.

---
 rtl/spi_xfer_scheduler.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_xfer_scheduler.sv
// spi_xfer_scheduler: round-robin arbiter that shares one SPI master between
// NUM_REQ requesters, sequences each transfer, waits for the mode-specific
// done strobes, returns the received word and enforces an idle gap.
module spi_xfer_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int SPI_TRF_BIT = 8,
    parameter int GAP_CYC     = 10,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [2*NUM_REQ-1:0]           req_mode,
    input  logic [SPI_TRF_BIT*NUM_REQ-1:0] req_data,
    output logic                           rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]     rsp_id,
    output logic [SPI_TRF_BIT-1:0]         rsp_data,
    output logic                           rsp_err,
    output logic [1:0]                     spi_req,
    output logic [SPI_TRF_BIT-1:0]         spi_din,
    input  logic [SPI_TRF_BIT-1:0]         spi_dout,
    input  logic                           spi_done_tx,
    input  logic                           spi_done_rx,
    output logic                           busy
);

    localparam int ID_W     = $clog2(NUM_REQ);
    localparam int TO_W     = $clog2(TIMEOUT_CYC) + 1;
    localparam int GAP_W    = $clog2(GAP_CYC + 1) + 1;
    localparam int GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_GAP     = 2'd2,
        S_NULLRSP = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [ID_W-1:0]          ptr_q, ptr_d;
    logic [ID_W-1:0]          id_q, id_d;
    logic [1:0]               mode_q, mode_d;
    logic [1:0]               spi_req_q, spi_req_d;
    logic [SPI_TRF_BIT-1:0]   spi_din_q, spi_din_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]          rsp_id_q, rsp_id_d;
    logic [SPI_TRF_BIT-1:0]   rsp_data_q, rsp_data_d;
    logic                     rsp_err_q, rsp_err_d;
    logic                     tx_seen_q, tx_seen_d;
    logic                     rx_seen_q, rx_seen_d;
    logic [TO_W-1:0]          to_cnt_q, to_cnt_d;
    logic [GAP_W-1:0]         gap_cnt_q, gap_cnt_d;

    logic                     grant_found;
    logic [ID_W-1:0]          grant_id;
    logic [ID_W:0]            arb_sum;
    logic [ID_W-1:0]          arb_cand;
    logic [1:0]               grant_mode;
    logic [SPI_TRF_BIT-1:0]   grant_data;
    logic [ID_W-1:0]          ptr_after;
    logic                     tx_now, rx_now, xfer_done, to_hit;

    // Round-robin search: first valid requester starting at ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        arb_sum     = '0;
        arb_cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            arb_sum = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (arb_sum >= (ID_W+1)'(NUM_REQ)) begin
                arb_sum = arb_sum - (ID_W+1)'(NUM_REQ);
            end
            arb_cand = arb_sum[ID_W-1:0];
            if (!grant_found && req_valid[arb_cand]) begin
                grant_found = 1'b1;
                grant_id    = arb_cand;
            end
        end
    end

    assign grant_mode = req_mode[2*grant_id +: 2];
    assign grant_data = req_data[grant_id*SPI_TRF_BIT +: SPI_TRF_BIT];
    assign ptr_after  = (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
    assign req_ready  = (state_q == S_IDLE && grant_found) ?
                        (NUM_REQ'(1) << grant_id) : '0;

    // Completion includes strobes arriving on the evaluating edge itself.
    assign tx_now    = tx_seen_q | spi_done_tx;
    assign rx_now    = rx_seen_q | spi_done_rx;
    assign xfer_done = (mode_q == 2'b01) ? tx_now :
                       (mode_q == 2'b10) ? rx_now :
                       (mode_q == 2'b11) ? (tx_now & rx_now) : 1'b0;
    assign to_hit    = (to_cnt_q == TO_W'(TIMEOUT_CYC-1));

    // Next-state and output logic for the transfer sequencer.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        mode_d      = mode_q;
        spi_req_d   = spi_req_q;
        spi_din_d   = spi_din_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        tx_seen_d   = tx_seen_q;
        rx_seen_d   = rx_seen_q;
        to_cnt_d    = to_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    ptr_d = ptr_after;
                    id_d  = grant_id;
                    if (grant_mode != 2'b00) begin
                        mode_d    = grant_mode;
                        spi_req_d = grant_mode;
                        spi_din_d = grant_data;
                        tx_seen_d = 1'b0;
                        rx_seen_d = 1'b0;
                        to_cnt_d  = '0;
                        state_d   = S_BUSY;
                    end else begin
                        // Null descriptor: answer immediately, no SPI activity.
                        rsp_valid_d = 1'b1;
                        rsp_id_d    = grant_id;
                        rsp_data_d  = '0;
                        rsp_err_d   = 1'b0;
                        state_d     = S_NULLRSP;
                    end
                end
            end
            S_NULLRSP: begin
                state_d = S_IDLE;
            end
            S_BUSY: begin
                tx_seen_d = tx_now;
                rx_seen_d = rx_now;
                if (xfer_done || to_hit) begin
                    // Completion has priority over a coincident timeout.
                    spi_req_d   = 2'b00;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_err_d   = !xfer_done;
                    rsp_data_d  = (xfer_done && mode_q != 2'b01) ? spi_dout : '0;
                    gap_cnt_d   = '0;
                    state_d     = (GAP_CYC == 0) ? S_IDLE : S_GAP;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_W'(GAP_LAST)) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            mode_q      <= 2'b00;
            spi_req_q   <= 2'b00;
            spi_din_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            tx_seen_q   <= 1'b0;
            rx_seen_q   <= 1'b0;
            to_cnt_q    <= '0;
            gap_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            mode_q      <= mode_d;
            spi_req_q   <= spi_req_d;
            spi_din_q   <= spi_din_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            tx_seen_q   <= tx_seen_d;
            rx_seen_q   <= rx_seen_d;
            to_cnt_q    <= to_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    assign spi_req   = spi_req_q;
    assign spi_din   = spi_din_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != S_IDLE);

endmodule
